// File: rtl/fpga_100hz_pkg.sv
// rtl/fpga_100hz_pkg.sv - shared constants, FSM encoding and range helper for the 100Hz monitor
package fpga_100hz_pkg;

    localparam int CYCLES_PER_100HZ = 250000;
    localparam int CNT_W            = 18;
    localparam logic [CNT_W-1:0] CNT_MAX = 18'h3FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        LOCK = 2'd2
    } mon_state_e;

    function automatic logic in_range(input logic [CNT_W-1:0] period, input int nominal, input int tol);
        int diff;
        diff = int'(period) - nominal;
        return (diff >= -tol) && (diff <= tol);
    endfunction

endpackage

// File: rtl/fpga_100hz_monitor_if.sv
// rtl/fpga_100hz_monitor_if.sv - reference input, clear and status bundle of the 100Hz monitor
interface fpga_100hz_monitor_if;
    import fpga_100hz_pkg::*;

    logic             clk100hz_in;
    logic             clr;
    logic             tick_pulse;
    logic [31:0]      tick_count;
    logic [CNT_W-1:0] period_cycles;
    logic             locked;
    logic             period_err;
    logic             lost_err;

    modport master (
        input  clk100hz_in, clr,
        output tick_pulse, tick_count, period_cycles, locked, period_err, lost_err
    );

    modport slave (
        output clk100hz_in, clr,
        input  tick_pulse, tick_count, period_cycles, locked, period_err, lost_err
    );

endinterface

// File: rtl/fpga_sync_edge.sv
// rtl/fpga_sync_edge.sv - synchronizer, optional glitch filter (FPGA_100HZ_MON_GLITCH_FILTER_EN), rise detect
module fpga_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 8
) (
    input  logic clk25mhz,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_cfg
        $error("fpga_sync_edge: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   sync_lvl;
    logic                   lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef FPGA_100HZ_MON_GLITCH_FILTER_EN
    localparam int FILT_CNT_W = $clog2(FILT_LEN + 1);

    logic                  filt_q, filt_d;
    logic [FILT_CNT_W-1:0] filt_cnt_q, filt_cnt_d;

    // The filtered level flips only once the synchronized level has disagreed for FILT_LEN cycles in a row.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (sync_lvl != filt_q) begin
            if (filt_cnt_q == FILT_CNT_W'(FILT_LEN - 1)) begin
                filt_d = sync_lvl;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk25mhz or negedge reset_n) begin
        if (!reset_n) begin
            filt_q     <= 1'b0;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_lvl;
`endif

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = lvl;
    end

    always_ff @(posedge clk25mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = lvl & ~prev_q;

endmodule

// File: rtl/fpga_100hz_monitor.sv
// rtl/fpga_100hz_monitor.sv - 100Hz reference period monitor with lock/loss detection and tick counter
// Glitch filter enabled by defining FPGA_100HZ_MON_GLITCH_FILTER_EN.
module fpga_100hz_monitor
    import fpga_100hz_pkg::*;
#(
    parameter int NOMINAL_CYCLES = CYCLES_PER_100HZ,
    parameter int TOL_CYCLES     = 250,
    parameter int LOCK_COUNT     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int FILT_LEN       = 8
) (
    input  logic                  clk25mhz,
    input  logic                  reset_n,
    fpga_100hz_monitor_if.master  mon
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    if (NOMINAL_CYCLES + TOL_CYCLES >= 262143 || LOCK_COUNT < 1) begin : g_bad_cfg
        $error("fpga_100hz_monitor: period window exceeds counter range or LOCK_COUNT < 1");
    end

    logic             rise;
    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic             tick_pulse_q, tick_pulse_d;
    logic [31:0]      tick_count_q, tick_count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             locked_q, locked_d;
    logic             period_err_q, period_err_d;
    logic             lost_err_q, lost_err_d;
    logic             perr_set, lost_set;

    fpga_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_sync_edge (
        .clk25mhz (clk25mhz),
        .reset_n  (reset_n),
        .din      (mon.clk100hz_in),
        .rise     (rise)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        good_d   = good_q;
        period_d = period_q;
        perr_set = 1'b0;
        lost_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = MEAS;
                    cnt_d   = CNT_W'(1);
                    good_d  = '0;
                end
            end
            MEAS, LOCK: begin
                if (rise) begin
                    cnt_d    = CNT_W'(1);
                    period_d = cnt_q;
                    if (in_range(cnt_q, NOMINAL_CYCLES, TOL_CYCLES)) begin
                        if (state_q == MEAS) begin
                            good_d = good_q + 1'b1;
                            if (good_q + 1'b1 == GOOD_W'(LOCK_COUNT)) begin
                                state_d = LOCK;
                            end
                        end
                    end else begin
                        state_d  = MEAS;
                        good_d   = '0;
                        perr_set = 1'b1;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    // Counter stays saturated for this cycle; IDLE zeroes it on the next.
                    state_d  = IDLE;
                    good_d   = '0;
                    lost_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                good_d  = '0;
            end
        endcase

        tick_pulse_d = rise;
        locked_d     = (state_q == LOCK);
        // clr has priority over a coincident edge and any coincident error.
        if (mon.clr) begin
            tick_count_d = '0;
            period_err_d = 1'b0;
            lost_err_d   = 1'b0;
        end else begin
            tick_count_d = rise ? tick_count_q + 1'b1 : tick_count_q;
            period_err_d = period_err_q | perr_set;
            lost_err_d   = lost_err_q | lost_set;
        end
    end

    always_ff @(posedge clk25mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            good_q       <= '0;
            tick_pulse_q <= 1'b0;
            tick_count_q <= '0;
            period_q     <= '0;
            locked_q     <= 1'b0;
            period_err_q <= 1'b0;
            lost_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            good_q       <= good_d;
            tick_pulse_q <= tick_pulse_d;
            tick_count_q <= tick_count_d;
            period_q     <= period_d;
            locked_q     <= locked_d;
            period_err_q <= period_err_d;
            lost_err_q   <= lost_err_d;
        end
    end

    assign mon.tick_pulse    = tick_pulse_q;
    assign mon.tick_count    = tick_count_q;
    assign mon.period_cycles = period_q;
    assign mon.locked        = locked_q;
    assign mon.period_err    = period_err_q;
    assign mon.lost_err      = lost_err_q;

endmodule

// File: tb/tb_fpga_100hz_monitor.sv
// tb/tb_fpga_100hz_monitor.sv - scoreboard bench for fpga_100hz_monitor (honours FPGA_100HZ_MON_GLITCH_FILTER_EN)
module tb_fpga_100hz_monitor;
    import fpga_100hz_pkg::*;

    localparam int NOM  = 100;
    localparam int TOL  = 5;
    localparam int FILT = 8;
`ifdef FPGA_100HZ_MON_GLITCH_FILTER_EN
    localparam int LAT = 2 + FILT;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [31:0] tc;
        logic [17:0] per;
        logic        lk;
        logic        pe;
        logic        lo;
    } exp_t;

    logic clk25mhz = 1'b0;
    logic reset_n  = 1'b0;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    fpga_100hz_monitor_if mon ();

    fpga_100hz_monitor #(
        .NOMINAL_CYCLES (NOM),
        .TOL_CYCLES     (TOL),
        .LOCK_COUNT     (4),
        .SYNC_STAGES    (2),
        .FILT_LEN       (FILT)
    ) dut (
        .clk25mhz (clk25mhz),
        .reset_n  (reset_n),
        .mon      (mon)
    );

    always #20 clk25mhz = ~clk25mhz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_edge(input logic [31:0] tc, input logic [17:0] per, input logic lk,
                               input logic pe, input logic lo);
        exp_t e;
        e.tc = tc; e.per = per; e.lk = lk; e.pe = pe; e.lo = lo;
        sb.push_back(e);
    endtask

    // Starts at a negedge with a rising reference edge; optional clr pulse at step clr_at and glitch.
    task automatic wave(input int hi, input int lo, input int clr_at = -1,
                        input int g_start = 0, input int g_len = 0);
        for (int i = 0; i < hi + lo; i++) begin
            mon.clk100hz_in = (i < hi) || (i >= g_start && i < g_start + g_len);
            mon.clr         = (i == clr_at);
            @(negedge clk25mhz);
            if (i == clr_at) begin
                check("clr_tick_count", mon.tick_count, 32'd0);
                check("clr_period_err", 32'(mon.period_err), 32'd0);
                check("clr_lost_err", 32'(mon.lost_err), 32'd0);
            end
        end
        mon.clr = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk25mhz);
            if (mon.tick_pulse === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_tick", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("tick_count", mon.tick_count, e.tc);
                    check("period_cycles", 32'(mon.period_cycles), 32'(e.per));
                    check("period_err", 32'(mon.period_err), 32'(e.pe));
                    check("lost_err", 32'(mon.lost_err), 32'(e.lo));
                    @(negedge clk25mhz);
                    check("locked", 32'(mon.locked), 32'(e.lk));
                    check("tick_width", 32'(mon.tick_pulse), 32'd0);
                end
            end
        end
    end

    initial begin : stimulus
        mon.clk100hz_in = 1'b0;
        mon.clr         = 1'b0;
        repeat (3) @(negedge clk25mhz);
        check("rst_tick_pulse", 32'(mon.tick_pulse), 32'd0);
        check("rst_tick_count", mon.tick_count, 32'd0);
        check("rst_period", 32'(mon.period_cycles), 32'd0);
        check("rst_locked", 32'(mon.locked), 32'd0);
        check("rst_period_err", 32'(mon.period_err), 32'd0);
        check("rst_lost_err", 32'(mon.lost_err), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk25mhz);

        // Acquire: first edge only starts measuring, lock on the fifth.
        expect_edge(32'd1, 18'd0,   1'b0, 1'b0, 1'b0); wave(50, 50);
        expect_edge(32'd2, 18'd100, 1'b0, 1'b0, 1'b0); wave(50, 50);
        expect_edge(32'd3, 18'd100, 1'b0, 1'b0, 1'b0); wave(50, 50);
        expect_edge(32'd4, 18'd100, 1'b0, 1'b0, 1'b0); wave(50, 50);
        expect_edge(32'd5, 18'd100, 1'b1, 1'b0, 1'b0); wave(55, 55);
        // Long period drops lock; clr coincident with the following tick.
        expect_edge(32'd6, 18'd110, 1'b0, 1'b1, 1'b0); wave(50, 50);
        expect_edge(32'd7, 18'd100, 1'b0, 1'b1, 1'b0); wave(50, 50, LAT + 1);
        expect_edge(32'd1, 18'd100, 1'b0, 1'b0, 1'b0); wave(50, 50);
        expect_edge(32'd2, 18'd100, 1'b0, 1'b0, 1'b0); wave(50, 50);
        expect_edge(32'd3, 18'd100, 1'b1, 1'b0, 1'b0); wave(50, 10);

        // Loss: jump the period counter near saturation and hold the input low.
        force dut.cnt_q = 18'h3FFF0;
        #1 release dut.cnt_q;
        repeat (15) @(negedge clk25mhz);
        check("lost_not_yet", 32'(mon.lost_err), 32'd0);
        @(negedge clk25mhz);
        check("lost_err_set", 32'(mon.lost_err), 32'd1);
        check("lost_tick_frozen", mon.tick_count, 32'd3);
        repeat (2) @(negedge clk25mhz);
        check("lost_unlocked", 32'(mon.locked), 32'd0);
        check("lost_period_kept", 32'(mon.period_cycles), 32'd100);
        repeat (5) @(negedge clk25mhz);

        // Edge after loss restarts measurement; standalone clr later clears lost_err.
        expect_edge(32'd4, 18'd100, 1'b0, 1'b0, 1'b1); wave(50, 50, 70);

        force dut.tick_count_q = 32'hFFFF_FFFF;
        #1 release dut.tick_count_q;
        expect_edge(32'd0, 18'd100, 1'b0, 1'b0, 1'b0);
`ifdef FPGA_100HZ_MON_GLITCH_FILTER_EN
        wave(50, 50, -1, 70, 3);
        expect_edge(32'd1, 18'd100, 1'b0, 1'b0, 1'b0); wave(50, 50);
`else
        expect_edge(32'd1, 18'd70, 1'b0, 1'b1, 1'b0);
        wave(50, 50, -1, 70, 3);
        expect_edge(32'd2, 18'd30, 1'b0, 1'b1, 1'b0); wave(50, 50);
`endif
        // clr in the same cycle as rise: the edge is not counted.
        expect_edge(32'd0, 18'd100, 1'b0, 1'b0, 1'b0); wave(50, 50, LAT);

        repeat (20) @(negedge clk25mhz);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
